// File: rtl/mod_arith_pkg.sv
// Shared helpers for the modular-arithmetic datapath: width helpers,
// the constant table of modulus multiples, and the serial FSM state type.
package mod_arith_pkg;

    localparam int MAX_K = 32;

    typedef logic [MAX_K-1:0][31:0] mult_tbl_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int num_digits(input int w, input int d);
        return (w + d - 1) / d;
    endfunction

    // Entry k holds k*MOD for k = 0 .. 2**(d+1)-1; higher entries stay zero.
    function automatic mult_tbl_t mult_table(input longint mod, input int d);
        mult_tbl_t tbl;
        tbl = '0;
        for (int k = 0; k < (1 << (d + 1)); k++) begin
            tbl[k] = 32'(mod * k);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/mod_digit_mac_reduce.sv
// One digit step of interleaved modular multiply: (acc*2**D + a*digit) mod MOD,
// with the quotient picked by parallel compares against constant multiples.
module mod_digit_mac_reduce
    import mod_arith_pkg::*;
#(
    parameter int MOD = 2011,
    parameter int W   = 11,
    parameter int D   = 3
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [D-1:0] digit,
    output logic [W-1:0] acc_nxt
);

    localparam int        TW  = W + D + 1;
    localparam int        K   = 1 << (D + 1);
    localparam mult_tbl_t TBL = mult_table(MOD, D);

    logic [TW-1:0] w_t;
    logic [TW-1:0] w_sel;

    assign w_t = TW'({acc, {D{1'b0}}}) + (TW'(a) * TW'(digit));

    // Multiples are monotonic, so the last one not exceeding t is q*MOD.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < K; k++) begin
            if (w_t >= TBL[k][TW-1:0]) w_sel = TBL[k][TW-1:0];
        end
    end

    assign acc_nxt = W'(w_t - w_sel);

endmodule

// File: rtl/mod_mult_serial.sv
// Digit-serial modular multiplier r = (a*b) mod MOD, D bits of b per cycle
// MSB-first, with valid/ready handshakes on input and output.
module mod_mult_serial
    import mod_arith_pkg::*;
#(
    parameter int MOD = 2011,
    parameter int W   = 11,
    parameter int D   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    output logic         err
);

    localparam int N  = num_digits(W, D);
    localparam int CW = cnt_w(N);
    localparam int BW = N * D;

    state_e         r_state;
    state_e         w_state_nxt;
    logic [W-1:0]   r_a;
    logic [BW-1:0]  r_b;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_err;

    logic           w_accept;
    logic           w_oor;
    logic [D-1:0]   w_digit;
    logic [W-1:0]   w_acc_nxt;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_oor    = (a >= W'(MOD)) || (b >= W'(MOD));
    assign w_digit  = r_b[r_cnt*D +: D];

    mod_digit_mac_reduce #(.MOD(MOD), .W(W), .D(D)) u_mac (
        .acc     (r_acc),
        .a       (r_a),
        .digit   (w_digit),
        .acc_nxt (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        r           = '0;
        err         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = w_oor ? DONE : RUN;
            end
            RUN: begin
                if (r_cnt == '0) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                r         = r_acc;
                err       = r_err;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Out-of-range pairs keep acc at zero, so DONE presents r=0 with err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= BW'(b);
            r_acc <= '0;
            r_cnt <= CW'(N - 1);
            r_err <= w_oor;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_mod_mult_serial.sv
// Bench for mod_mult_serial: directed corner cases on the default build, then
// randomized handshake sweeps on several MOD/W/D builds against (a*b)%MOD.
module tb_mod_mult_serial;

    localparam int NC = 5;

    function automatic int cfg_mod(input int g);
        return (g == 4) ? 13 : 2011;
    endfunction

    function automatic int cfg_w(input int g);
        return (g == 4) ? 4 : 11;
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            1:       return 1;
            2:       return 2;
            3:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int ndig(input int g);
        return (cfg_w(g) + cfg_d(g) - 1) / cfg_d(g);
    endfunction

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [NC];
    logic        in_ready_v  [NC];
    logic        out_valid_v [NC];
    logic        out_ready_v [NC];
    logic        err_v       [NC];
    logic [10:0] a_v         [NC];
    logic [10:0] b_v         [NC];
    logic [10:0] r_v         [NC];

    int ntests = 0;
    int nfail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int GW = cfg_w(g);
        logic [GW-1:0] w_r;
        mod_mult_serial #(.MOD(cfg_mod(g)), .W(GW), .D(cfg_d(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g][GW-1:0]),
            .b         (b_v[g][GW-1:0]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .r         (w_r),
            .err       (err_v[g])
        );
        assign r_v[g] = 11'(w_r);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input longint obs, input longint exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
        end
    endtask

    // Wait for out_valid on build g while scribbling on the idle-ignored inputs.
    task automatic wait_result(input int g, output int lat);
        lat = 0;
        while (!out_valid_v[g] && lat < 64) begin
            a_v[g]        = 11'($urandom);
            b_v[g]        = 11'($urandom);
            in_valid_v[g] = 1'($urandom);
            tick();
            lat++;
        end
        in_valid_v[g] = 1'b0;
    endtask

    task automatic do_op(input int g, input longint av, input longint bv,
                         input string tag, input int bp);
        longint mod;
        longint exp_r;
        bit     exp_err;
        int     lat;
        mod     = cfg_mod(g);
        exp_err = (av >= mod) || (bv >= mod);
        exp_r   = exp_err ? 0 : (av * bv) % mod;
        chk(tag, "in_ready_idle", in_ready_v[g], 1);
        a_v[g]        = 11'(av);
        b_v[g]        = 11'(bv);
        in_valid_v[g] = 1'b1;
        tick();
        in_valid_v[g] = 1'b0;
        // Latency counted in edges after the accepting edge; error results
        // are already visible right after it.
        wait_result(g, lat);
        chk(tag, "latency", lat, exp_err ? 0 : ndig(g));
        chk(tag, "r", r_v[g], exp_r);
        chk(tag, "err", err_v[g], exp_err);
        for (int i = 0; i < bp; i++) begin
            in_valid_v[g] = 1'($urandom);
            a_v[g]        = 11'($urandom);
            tick();
            chk(tag, "bp_valid", out_valid_v[g], 1);
            chk(tag, "bp_r", r_v[g], exp_r);
            chk(tag, "bp_err", err_v[g], exp_err);
            chk(tag, "bp_in_ready", in_ready_v[g], 0);
        end
        in_valid_v[g]  = 1'b0;
        out_ready_v[g] = 1'b1;
        tick();
        out_ready_v[g] = 1'b0;
        chk(tag, "drained", out_valid_v[g], 0);
        chk(tag, "back_idle", in_ready_v[g], 1);
    endtask

    initial begin
        int     lat;
        int     stale;
        longint mod;
        for (int g = 0; g < NC; g++) begin
            in_valid_v[g]  = 1'b0;
            out_ready_v[g] = 1'b0;
            a_v[g]         = '0;
            b_v[g]         = '0;
        end
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset", "in_ready", in_ready_v[0], 1);
        chk("reset", "out_valid", out_valid_v[0], 0);
        chk("reset", "r", r_v[0], 0);
        chk("reset", "err", err_v[0], 0);
        rst_n = 1'b1;
        tick();

        do_op(0, 2010, 2010, "corner_max", 0);
        do_op(0, 1000, 3,    "small_b",    0);
        do_op(0, 1234, 567,  "mid",        0);
        do_op(0, 1024, 1024, "pow2",       0);
        do_op(0, 0,    1999, "zero_a",     0);
        do_op(0, 1999, 0,    "zero_b",     0);
        do_op(0, 2011, 5,    "oor_a",      0);
        do_op(0, 5,    2047, "oor_b",      0);
        do_op(0, 17,   19,   "after_err",  0);
        do_op(0, 321,  1777, "backpress",  5);

        // New pair offered together with out_ready: only the drain acts.
        a_v[0] = 11'd100; b_v[0] = 11'd200; in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        wait_result(0, lat);
        chk("overlap", "first_r", r_v[0], (100 * 200) % 2011);
        a_v[0] = 11'd300; b_v[0] = 11'd400;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        tick();
        out_ready_v[0] = 1'b0;
        chk("overlap", "drained", out_valid_v[0], 0);
        chk("overlap", "idle", in_ready_v[0], 1);
        tick();
        in_valid_v[0] = 1'b0;
        chk("overlap", "accepted", in_ready_v[0], 0);
        a_v[0] = 11'd7; b_v[0] = 11'd7;
        tick();
        lat = 0;
        while (!out_valid_v[0] && lat < 64) begin tick(); lat++; end
        chk("overlap", "second_r", r_v[0], (300 * 400) % 2011);
        out_ready_v[0] = 1'b1;
        tick();
        out_ready_v[0] = 1'b0;

        // Reset in the second RUN cycle discards the partial product.
        a_v[0] = 11'd50; b_v[0] = 11'd60; in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_run", "in_ready", in_ready_v[0], 1);
        chk("rst_run", "out_valid", out_valid_v[0], 0);
        chk("rst_run", "r", r_v[0], 0);
        chk("rst_run", "err", err_v[0], 0);
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_v[0]) stale++;
        end
        chk("rst_run", "stale_results", stale, 0);
        do_op(0, 7, 9, "post_reset", 0);

        for (int g = 0; g < NC; g++) begin
            mod = cfg_mod(g);
            do_op(g, mod - 1, mod - 1, $sformatf("sweep%0d_max", g), 0);
            for (int i = 0; i < 25; i++) begin
                int gap;
                gap = $urandom_range(2, 0);
                for (int j = 0; j < gap; j++) tick();
                do_op(g, longint'($urandom_range(int'(mod) - 1, 0)),
                         longint'($urandom_range(int'(mod) - 1, 0)),
                      $sformatf("sweep%0d_%0d", g, i), int'($urandom_range(3, 0)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
